usb_ext_fifo_writer: RTL and testbench

USB_EXT_FIFO_WRITER -- requirements
Module: usb_ext_fifo_writer

---
 rtl/usb_ext_fifo_writer_if.sv | 25 ++
 rtl/usb_ext_fifo_writer.sv | 131 +++++++++++++
 tb/tb_usb_ext_fifo_writer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_ext_fifo_writer_if.sv
// Bus between the FIFO writer and an external FX2-style slave FIFO.
// The writer drives data and strobes; the slave FIFO returns the full flag.
interface usb_ext_fifo_writer_if;
  logic [15:0] usb_fd;
  logic        usb_slwr_n;
  logic        usb_pktend_n;
  logic [1:0]  usb_fifoadr;
  logic        usb_full_n;

  modport master (
    output usb_fd,
    output usb_slwr_n,
    output usb_pktend_n,
    output usb_fifoadr,
    input  usb_full_n
  );

  modport slave (
    input  usb_fd,
    input  usb_slwr_n,
    input  usb_pktend_n,
    input  usb_fifoadr,
    output usb_full_n
  );
endinterface

// File: rtl/usb_ext_fifo_writer.sv
// Buffers merged channel words and streams them into an external USB slave FIFO,
// issuing a packet-end strobe when a flush commits a partial bulk packet.
module usb_ext_fifo_writer #(
  parameter int         PKT_WORDS = 256,
  parameter int         BUF_DEPTH = 16,
  parameter logic [1:0] EP_ADDR   = 2'b10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  din,
  input  logic                         din_en,
  input  logic                         flush_req,
  usb_ext_fifo_writer_if.master        usb,
  output logic                         buf_overflow,
  output logic                         busy
);

  localparam int             AW       = $clog2(BUF_DEPTH);
  localparam int             WCW      = $clog2(PKT_WORDS) + 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]    ONE_CNT  = (AW+1)'(1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(PKT_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PKTEND} state_t;

  state_t         state, state_next;
  logic [15:0]    mem [BUF_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_next;
  logic [WCW-1:0] word_cnt, word_cnt_next;
  logic           flush_pending, flush_pending_next, flush_clear;
  logic           buf_empty, buf_full, push, pop;
  logic           slwr_n_next, pktend_n_next, busy_next;

  assign buf_empty = (count == '0);
  assign buf_full  = (count == FULL_CNT);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push      = din_en && (!buf_full || pop);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    slwr_n_next   = 1'b1;
    pktend_n_next = 1'b1;
    word_cnt_next = word_cnt;
    flush_clear   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!buf_empty) begin
          state_next = S_WRITE;
        end else if (flush_pending) begin
          if (word_cnt != '0) state_next  = S_PKTEND;
          else                flush_clear = 1'b1;
        end
      end
      S_WRITE: begin
        if (!buf_empty && usb.usb_full_n) begin
          pop           = 1'b1;
          slwr_n_next   = 1'b0;
          // FX2 auto-commits a full packet, so the count simply wraps.
          word_cnt_next = (word_cnt == WC_LAST) ? '0 : word_cnt + WCW'(1);
          if (count == ONE_CNT && !din_en) state_next = S_IDLE;
        end else if (buf_empty) begin
          state_next = S_IDLE;
        end
      end
      S_PKTEND: begin
        if (usb.usb_full_n) begin
          pktend_n_next = 1'b0;
          word_cnt_next = '0;
          flush_clear   = 1'b1;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + ONE_CNT;
    else if (!push && pop) count_next = count - ONE_CNT;
  end

  // A new request wins over a same-cycle clear so it is serviced on the next pass.
  assign flush_pending_next = flush_req || (flush_pending && !flush_clear);
  assign busy_next = (count_next != '0) || flush_pending_next || (state_next != S_IDLE);

  // NOTE: buffer storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      word_cnt         <= '0;
      flush_pending    <= 1'b0;
      usb.usb_fd       <= 16'h0000;
      usb.usb_slwr_n   <= 1'b1;
      usb.usb_pktend_n <= 1'b1;
      usb.usb_fifoadr  <= EP_ADDR;
      buf_overflow     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        usb.usb_fd <= mem[rd_ptr];
      end
      count            <= count_next;
      word_cnt         <= word_cnt_next;
      flush_pending    <= flush_pending_next;
      usb.usb_slwr_n   <= slwr_n_next;
      usb.usb_pktend_n <= pktend_n_next;
      usb.usb_fifoadr  <= EP_ADDR;
      if (din_en && !push) buf_overflow <= 1'b1;
      busy             <= busy_next;
    end
  end

endmodule

// File: tb/tb_usb_ext_fifo_writer.sv
// Scoreboard bench for usb_ext_fifo_writer: stimulus queues expected writes and
// packet ends, an independent negedge monitor pops and compares them.
module tb_usb_ext_fifo_writer;
  localparam int         PKT_WORDS = 256;
  localparam int         BUF_DEPTH = 16;
  localparam logic [1:0] EP_ADDR   = 2'b10;

  typedef struct packed {
    logic        is_end;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        din_en, flush_req;
  logic        buf_overflow, busy;

  usb_ext_fifo_writer_if usb ();

  usb_ext_fifo_writer #(
    .PKT_WORDS (PKT_WORDS),
    .BUF_DEPTH (BUF_DEPTH),
    .EP_ADDR   (EP_ADDR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .din_en       (din_en),
    .flush_req    (flush_req),
    .usb          (usb.master),
    .buf_overflow (buf_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, wr_cnt = 0, end_cnt = 0;
  int   first_wr_cyc = 0, last_wr_cyc = 0;
  bit   lat_arm = 1'b0, prev_end = 1'b0;
  logic full_at_edge = 1'b1;
  int   model_pkt = 0;  // words committed to the current USB packet

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w, input bit expect_out);
    din    = w;
    din_en = 1'b1;
    if (expect_out) begin
      sb.push_back('{1'b0, w});
      model_pkt = (model_pkt + 1) % PKT_WORDS;
    end
    tick();
  endtask

  task automatic do_flush();
    din_en    = 1'b0;
    flush_req = 1'b1;
    if (model_pkt != 0) sb.push_back('{1'b1, 16'h0000});
    model_pkt = 0;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    din_en         = 1'b0;
    usb.usb_full_n = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    check("idle_timeout", busy, 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_en    = 1'b0;
    flush_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    model_pkt = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    full_at_edge = usb.usb_full_n;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (usb.usb_slwr_n === 1'b0) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (lat_arm) begin
        first_wr_cyc = cyc;
        lat_arm      = 1'b0;
      end
      check("wr_while_full", full_at_edge, 1);
      check("wr_with_pktend", usb.usb_pktend_n, 1);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got write of %0h expected no write (cycle %0d)", usb.usb_fd, cyc);
      end else begin
        e = sb.pop_front();
        check("wr_kind", e.is_end, 0);
        check("wr_data", usb.usb_fd, e.data);
      end
    end
    if (usb.usb_pktend_n === 1'b0) begin
      end_cnt++;
      check("pktend_width", prev_end, 0);
      check("pktend_while_full", full_at_edge, 1);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pktend_unexpected: got pktend expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("pktend_kind", e.is_end, 1);
      end
    end
    prev_end = (usb.usb_pktend_n === 1'b0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, wr0, end0;
    din            = '0;
    din_en         = 1'b0;
    flush_req      = 1'b0;
    usb.usb_full_n = 1'b1;
    reset          = 1'b1;
    repeat (3) tick();
    check("rst_slwr_n", usb.usb_slwr_n, 1);
    check("rst_pktend_n", usb.usb_pktend_n, 1);
    check("rst_fd", usb.usb_fd, 16'h0000);
    check("rst_fifoadr", usb.usb_fifoadr, EP_ADDR);
    check("rst_overflow", buf_overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Full packet stream: auto-commit, no pktend afterwards.
    wr0 = wr_cnt; end0 = end_cnt;
    lat_arm = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < PKT_WORDS; i++) push_word(16'(i), 1'b1);
    wait_idle(2000);
    check("stream_latency", first_wr_cyc - e0, 2);
    check("stream_count", wr_cnt - wr0, PKT_WORDS);
    check("stream_back_to_back", last_wr_cyc - first_wr_cyc, PKT_WORDS - 1);
    do_flush();
    wait_idle(200);
    check("stream_no_pktend", end_cnt - end0, 0);

    // Backpressure window over cycles 3..10 of an 8-word burst.
    wr0 = wr_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) push_word(16'hB000 + 16'(i), 1'b1);
        din_en = 1'b0;
      end
      begin
        repeat (3) tick();
        usb.usb_full_n = 1'b0;
        repeat (8) tick();
        usb.usb_full_n = 1'b1;
      end
    join
    wait_idle(200);
    check("bp_count", wr_cnt - wr0, 8);
    do_flush();
    wait_idle(200);

    // Partial packet flush, then a flush with nothing pending.
    wr0 = wr_cnt; end0 = end_cnt;
    for (int i = 0; i < 5; i++) push_word(16'hC000 + 16'(i), 1'b1);
    do_flush();
    wait_idle(200);
    check("flush_wr_count", wr_cnt - wr0, 5);
    check("flush_pktend_count", end_cnt - end0, 1);
    end0 = end_cnt;
    do_flush();
    wait_idle(200);
    check("flush_empty_no_pktend", end_cnt - end0, 0);

    // Overflow: 17 words into a 16-word buffer while the USB FIFO is full.
    wr0 = wr_cnt;
    usb.usb_full_n = 1'b0;
    tick();
    for (int i = 0; i <= BUF_DEPTH; i++) begin
      push_word(16'hD000 + 16'(i), i < BUF_DEPTH);
      if (i == BUF_DEPTH - 1) check("ovf_before_drop", buf_overflow, 0);
    end
    din_en = 1'b0;
    check("ovf_after_drop", buf_overflow, 1);
    wait_idle(200);
    check("ovf_wr_count", wr_cnt - wr0, BUF_DEPTH);
    check("ovf_sticky", buf_overflow, 1);
    do_reset();
    check("ovf_cleared_by_reset", buf_overflow, 0);

    // Full buffer with pops: simultaneous push and pop must not drop.
    wr0 = wr_cnt;
    usb.usb_full_n = 1'b0;
    tick();
    for (int i = 0; i < 56; i++) begin
      if (i == BUF_DEPTH) begin
        usb.usb_full_n = 1'b1;
        lat_arm        = 1'b1;
      end
      push_word(16'hE000 + 16'(i), 1'b1);
    end
    wait_idle(300);
    check("fullpop_no_overflow", buf_overflow, 0);
    check("fullpop_count", wr_cnt - wr0, 56);
    check("fullpop_rate", last_wr_cyc - first_wr_cyc, 55);
    do_flush();
    wait_idle(200);

    // Reset during an active burst.
    for (int i = 0; i < 12; i++) push_word(16'hF000 + 16'(i), 1'b1);
    reset  = 1'b1;
    din_en = 1'b0;
    tick();
    check("midrst_slwr_n", usb.usb_slwr_n, 1);
    check("midrst_pktend_n", usb.usb_pktend_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_overflow", buf_overflow, 0);
    reset = 1'b0;
    sb.delete();
    model_pkt = 0;
    end0 = end_cnt;
    tick();
    do_flush();
    wait_idle(200);
    check("midrst_no_pktend", end_cnt - end0, 0);

    // Randomised bursts with random backpressure and optional flushes.
    for (int b = 0; b < 40; b++) begin
      int len;
      wait_idle(2000);
      len = $urandom_range(1, BUF_DEPTH);
      for (int j = 0; j < len; j++) begin
        int gap;
        gap    = $urandom_range(0, 2);
        din_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
          usb.usb_full_n = ($urandom_range(0, 3) != 0);
          tick();
        end
        usb.usb_full_n = ($urandom_range(0, 3) != 0);
        push_word(16'($urandom), 1'b1);
      end
      din_en = 1'b0;
      if ($urandom_range(0, 1) == 1) do_flush();
    end
    wait_idle(2000);
    do_flush();
    wait_idle(2000);
    check("final_sb_empty", sb.size(), 0);
    check("final_no_overflow", buf_overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
